// File: rtl/io_display_timer.sv
// IO-bus peripheral: synchronized switches, 8-digit multiplexed hex display with
// decimal points, and a free-running millisecond timer with an atomic high-byte shadow.
module io_display_timer #(
    parameter int REFRESH_DIV    = 1024,
    parameter int TIMER_PRESCALE = 5000
) (
    input  logic       i_oszClk,
    input  logic       i_resetn,
    input  logic       i_ioNCE,
    input  logic [7:0] i_ioAddress,
    input  logic       i_ioNOE,
    input  logic       i_ioNWE,
    input  logic [7:0] i_bus,
    output logic [7:0] o_bus,
    output logic       o_busNOE,
    input  logic [7:0] i_switches,
    output logic [7:0] o_cathodes,
    output logic [7:0] o_anodes
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRESC_LAST   = PW'(TIMER_PRESCALE - 1);

    logic [7:0]    sw_meta_reg, sw_sync_reg;
    logic          nwe_prev_reg, read_prev_reg;
    logic [7:0]    disp_buf_reg [4];
    logic [7:0]    dp_mask_reg;
    logic [15:0]   timer_reg;
    logic [PW-1:0] presc_reg;
    logic [7:0]    shadow_reg;
    logic [RW-1:0] refresh_reg;
    logic [2:0]    scan_reg;
    logic [7:0]    anodes_reg, cathodes_reg;

    logic       hit, read_active, read_start, write_commit;
    logic [7:0] read_data;
    logic [3:0] buf_we;
    logic [3:0] digit_nib;
    logic [7:0] digit_byte;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        hit       = 1'b1;
        read_data = 8'h00;
        case (i_ioAddress)
            8'h01:                    read_data = sw_sync_reg;
            8'h10, 8'h11, 8'h12, 8'h13: read_data = disp_buf_reg[i_ioAddress[1:0]];
            8'h14:                    read_data = dp_mask_reg;
            8'h20:                    read_data = timer_reg[7:0];
            8'h21:                    read_data = shadow_reg;
            default:                  hit = 1'b0;
        endcase
    end

    assign read_active  = ~i_ioNCE & ~i_ioNOE;
    assign read_start   = read_active & ~read_prev_reg;
    // Edge-detect on NWE so a long write strobe commits only once.
    assign write_commit = ~i_ioNCE & ~i_ioNWE & nwe_prev_reg;
    assign o_busNOE     = i_ioNCE | i_ioNOE | ~hit;
    assign o_bus        = o_busNOE ? 8'h00 : read_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_buf_we
            assign buf_we[gi] = write_commit && (i_ioAddress == 8'(8'h10 + gi));
        end
    endgenerate

    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            sw_meta_reg   <= 8'h00;
            sw_sync_reg   <= 8'h00;
            nwe_prev_reg  <= 1'b1;
            read_prev_reg <= 1'b0;
            dp_mask_reg   <= 8'h00;
            shadow_reg    <= 8'h00;
            for (int i = 0; i < 4; i++) disp_buf_reg[i] <= 8'h00;
        end else begin
            sw_meta_reg   <= i_switches;
            sw_sync_reg   <= sw_meta_reg;
            nwe_prev_reg  <= i_ioNCE | i_ioNWE;
            read_prev_reg <= read_active;
            for (int i = 0; i < 4; i++) begin
                if (buf_we[i]) disp_buf_reg[i] <= i_bus;
            end
            if (write_commit && i_ioAddress == 8'h14) dp_mask_reg <= i_bus;
            if (read_start && i_ioAddress == 8'h20) shadow_reg <= timer_reg[15:8];
        end
    end

    // A clear takes priority over a simultaneous prescaler wrap.
    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            timer_reg <= 16'h0000;
            presc_reg <= '0;
        end else if (write_commit && i_ioAddress == 8'h20) begin
            timer_reg <= 16'h0000;
            presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            timer_reg <= timer_reg + 16'd1;
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign digit_byte = disp_buf_reg[scan_reg[2:1]];
    assign digit_nib  = scan_reg[0] ? digit_byte[7:4] : digit_byte[3:0];

    always_ff @(posedge i_oszClk or negedge i_resetn) begin
        if (!i_resetn) begin
            refresh_reg  <= '0;
            scan_reg     <= 3'd0;
            anodes_reg   <= 8'hFF;
            cathodes_reg <= 8'hFF;
        end else begin
            if (refresh_reg == REFRESH_LAST) begin
                refresh_reg <= '0;
                scan_reg    <= scan_reg + 3'd1;
            end else begin
                refresh_reg <= refresh_reg + 1'b1;
            end
            anodes_reg   <= ~(8'd1 << scan_reg);
            cathodes_reg <= {~dp_mask_reg[scan_reg], hex7(digit_nib)};
        end
    end

    assign o_anodes   = anodes_reg;
    assign o_cathodes = cathodes_reg;
endmodule
